mem_line_serializer: RTL

- Sits directly downstream of the cache datapath/control memory port.
- Accepts one 16B line request (mem_req_16B_t) and splits it into four 4B word requests (mem_req_4B_t) to a word-wide backing memory.
- Collects the four 4B word responses, assembles them into one mem_resp_16B_t, and returns it to the cache.
- Used for refill (read) and evict (write) traffic; keeps up to p_max_outstanding word requests in flight.

---
 rtl/mem_line_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_line_serializer.sv
// rtl/mem_line_serializer.sv - splits 16B line requests into four 4B word requests and reassembles the response
//
// Purpose:
//   Sits between the cache memory port and a word-wide backing memory.
//   A latched line request is issued as four word requests (word k at
//   line_base + 4k, opaque = k), with at most p_max_outstanding unanswered
//   at any time. In-order word responses are assembled into the line.
//   Read-like types (READ and unsupported 3..7) return the assembled line.
//   WRITE/INIT return zero data.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   linereq_*         16B line request in  (val/rdy, 175-bit msg)
//   lineresp_*        16B line response out (val/rdy, 145-bit msg)
//   wordreq_*         4B word request out  (val/rdy, 77-bit msg)
//   wordresp_*        4B word response in  (val/rdy, 47-bit msg)

module mem_line_serializer #(
  parameter int p_max_outstanding = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         linereq_val,
  output logic         linereq_rdy,
  input  logic [174:0] linereq_msg,
  output logic         lineresp_val,
  input  logic         lineresp_rdy,
  output logic [144:0] lineresp_msg,
  output logic         wordreq_val,
  input  logic         wordreq_rdy,
  output logic [76:0]  wordreq_msg,
  input  logic         wordresp_val,
  output logic         wordresp_rdy,
  input  logic [46:0]  wordresp_msg
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [2:0] max_out = 3'(p_max_outstanding);

  state_t       state;
  logic [2:0]   req_cnt;
  logic [2:0]   resp_cnt;
  logic [127:0] line_data;
  logic [2:0]   line_type;
  logic [7:0]   line_opaque;
  logic [27:0]  line_addr;

  logic         is_write_type;
  logic [1:0]   word_idx;
  logic [2:0]   in_flight;
  logic         wordreq_fire;
  logic         wordresp_fire;

  // Fields that play no part in serialization: request len, the byte
  // offset within the line, and everything but data in word responses.
  logic unused_bits;
  assign unused_bits = ^{linereq_msg[131:128], linereq_msg[135:132], wordresp_msg[46:32]};

  assign is_write_type = (line_type == 3'd1) || (line_type == 3'd2);
  assign word_idx      = req_cnt[1:0];
  // resp_cnt never passes req_cnt, so this difference cannot underflow.
  assign in_flight     = req_cnt - resp_cnt;

  assign linereq_rdy  = (state == IDLE);
  assign lineresp_val = (state == RESP);
  assign wordreq_val  = (state == BUSY) && (req_cnt < 3'd4) && (in_flight < max_out);
  assign wordresp_rdy = (state == BUSY) && (resp_cnt < req_cnt);

  assign wordreq_fire  = wordreq_val && wordreq_rdy;
  assign wordresp_fire = wordresp_val && wordresp_rdy;

  assign wordreq_msg = {line_type, 6'd0, word_idx, line_addr, word_idx, 2'b00, 2'b00,
                        line_data[{word_idx, 5'd0} +: 32]};

  assign lineresp_msg = {line_type, line_opaque, 2'b00, 4'b0000,
                         is_write_type ? 128'd0 : line_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_cnt     <= 3'd0;
      resp_cnt    <= 3'd0;
      line_data   <= 128'd0;
      line_type   <= 3'd0;
      line_opaque <= 8'd0;
      line_addr   <= 28'd0;
    end else begin
      case (state)
        IDLE: begin
          if (linereq_val) begin
            line_type   <= linereq_msg[174:172];
            line_opaque <= linereq_msg[171:164];
            line_addr   <= linereq_msg[163:136];
            line_data   <= linereq_msg[127:0];
            req_cnt     <= 3'd0;
            resp_cnt    <= 3'd0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (wordreq_fire) begin
            req_cnt <= req_cnt + 3'd1;
          end
          if (wordresp_fire) begin
            // Writes keep their outgoing data; the response is zeroed on output.
            if (!is_write_type) begin
              line_data[{resp_cnt[1:0], 5'd0} +: 32] <= wordresp_msg[31:0];
            end
            resp_cnt <= resp_cnt + 3'd1;
            if (resp_cnt == 3'd3) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (lineresp_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
